vend_credit_controller: RTL and testbench
=========================================

// Module: vend_credit_controller
// PURPOSE
//  Credit FSM for the vending machine. Accepts coins, keeps the 4-bit credit code in 5-cent units
//  (0..12 = 0..60 c) that drives the display digit decoders, sequences vend and change return.
//  Sits between the coin acceptor/keypad and the display decoders, dispenser and change hopper.
// PARAMETERS
//  PRICE_UNITS  7   item price in 5-cent units (7 = 35 c); legal range 1..MAX_UNITS
//  MAX_UNITS    12  credit ceiling in 5-cent units (12 = 60 c); must be <= 15
//  VEND_CYCLES  4   dispense strobe length in clocks; must be >= 1
// PORTS
//  clk            in   1  clock; all logic on rising edge
//  rst            in   1  synchronous, active-high reset
//  coin_valid     in   1  one-cycle strobe, coin present on coin_type
//  coin_type      in   2  00 nickel = 1 unit, 01 dime = 2, 10 quarter = 5, 11 slug (always rejected)
//  select         in   1  vend request, level sampled each cycle
//  cancel         in   1  refund request, level sampled each cycle
//  credit         out  4  current credit code {a3,a2,a1,a0}, 0..MAX_UNITS, to the digit decoders
//  coin_reject    out  1  one-cycle pulse, coin returned to the customer
//  dispense       out  1  high for exactly VEND_CYCLES cycles per vend
//  change_nickel  out  1  one pulse per returned 5-cent unit
//  busy           out  1  high in VEND or REFUND
// BEHAVIOUR
//  - Reset: state IDLE. credit, coin_reject, dispense, change_nickel and busy are 0 in the cycle after rst.
//    Reset during VEND or REFUND aborts it. Remaining credit is discarded.
//  - States: IDLE (credit==0), ACCUM (credit>0), VEND, REFUND. All outputs are registered.
//  - Priority in IDLE/ACCUM when events coincide: cancel > select > coin.
//  - Coin (IDLE/ACCUM, no cancel and no accepted select that cycle):
//    - if type!=11 and credit+value <= MAX_UNITS: credit += value at that edge; IDLE -> ACCUM.
//    - otherwise credit is unchanged and coin_reject = 1 in the next cycle.
//  - A coin arriving in the same cycle as a cancel, an accepted select, VEND or REFUND is rejected
//    in the same way (coin_reject pulse, credit unchanged).
//  - select with credit >= PRICE_UNITS: credit -= PRICE_UNITS, go to VEND. select with credit < PRICE_UNITS
//    is ignored with no output.
//  - VEND: dispense = 1 for VEND_CYCLES cycles, starting the cycle after select is sampled.
//    Exit to REFUND if credit>0, otherwise to IDLE. select and cancel are ignored in VEND.
//  - cancel with credit>0: go to REFUND. cancel with credit==0: no effect.
//  - REFUND: each cycle, change_nickel = 1 and credit decrements by 1.
//    The edge that takes credit 1->0 also moves the state to IDLE.
//    N units of credit give exactly N consecutive pulses. select and cancel are ignored.
//  - credit never exceeds MAX_UNITS. Codes 13..15 are never driven. No wrap-around in either direction.
//  - Latency: coin to credit update 1 cycle. cancel to first change_nickel 1 cycle.
// TESTING
//  1. Pulse rst mid-VEND with credit 3 -> next cycle: credit 0, dispense 0, busy 0, no change_nickel ever.
//  2. quarter then dime, then select -> credit 5, 7, then 0. dispense high 4 cycles.
//     change_nickel never asserts. Returns to IDLE.
//  3. Two quarters (credit 10), select -> dispense 4 cycles.
//     Then 3 consecutive change_nickel pulses with credit 3, 2, 1. Then credit 0, IDLE.
//  4. Fill to 12 (quarter, quarter, dime), then a nickel -> coin_reject pulse, credit stays 12.
//     A coin_type=11 coin at credit 0 -> coin_reject pulse, credit stays 0.
//  5. credit 5, select -> ignored, credit 5, no dispense. Same cycle select+cancel+nickel at credit 6
//     -> coin_reject pulse, then 6 change_nickel pulses, credit 0.
//  6. Dime inserted during REFUND or VEND -> coin_reject pulse, credit sequence unaffected.

Source files
------------

// File: rtl/vend_credit_controller.sv
// Vending machine credit FSM: accepts coins, holds the credit code in 5-cent units,
// sequences a timed vend and a one-nickel-per-cycle change return.
module vend_credit_controller #(
    parameter int unsigned PRICE_UNITS = 7,
    parameter int unsigned MAX_UNITS   = 12,
    parameter int unsigned VEND_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       select,
    input  logic       cancel,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       dispense,
    output logic       change_nickel,
    output logic       busy
);

    localparam int unsigned CW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam logic [3:0] PRICE = 4'(PRICE_UNITS);
    localparam logic [4:0] MAX   = 5'(MAX_UNITS);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        VEND,
        REFUND
    } state_t;

    state_t        state, state_n;
    logic [3:0]    credit_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          reject_n, dispense_n, change_n, busy_n;
    logic [2:0]    coin_value;
    logic [4:0]    sum;

    always_comb begin
        case (coin_type)
            2'b00:   coin_value = 3'd1;
            2'b01:   coin_value = 3'd2;
            2'b10:   coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    end

    assign sum = {1'b0, credit} + {2'b00, coin_value};

    always_comb begin
        state_n    = state;
        credit_n   = credit;
        cnt_n      = cnt;
        reject_n   = 1'b0;
        dispense_n = 1'b0;
        change_n   = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (cancel) begin
                    // A cancel swallows any coin that cycle, even at zero credit
                    reject_n = coin_valid;
                    if (credit != '0) begin
                        state_n  = REFUND;
                        change_n = 1'b1;
                    end
                end else if (select && (credit >= PRICE)) begin
                    reject_n   = coin_valid;
                    credit_n   = credit - PRICE;
                    state_n    = VEND;
                    dispense_n = 1'b1;
                    cnt_n      = CW'(VEND_CYCLES - 1);
                end else if (coin_valid) begin
                    if ((coin_type != 2'b11) && (sum <= MAX)) begin
                        credit_n = sum[3:0];
                        state_n  = ACCUM;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            VEND: begin
                reject_n = coin_valid;
                if (cnt == '0) begin
                    if (credit != '0) begin
                        state_n  = REFUND;
                        change_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n      = cnt - 1'b1;
                    dispense_n = 1'b1;
                end
            end
            REFUND: begin
                // The pulse shown alongside credit N pays out that unit; the decrement lands at the same edge
                reject_n = coin_valid;
                if (credit <= 4'd1) begin
                    credit_n = '0;
                    state_n  = IDLE;
                end else begin
                    credit_n = credit - 1'b1;
                    change_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == VEND) || (state_n == REFUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            credit        <= '0;
            cnt           <= '0;
            coin_reject   <= 1'b0;
            dispense      <= 1'b0;
            change_nickel <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            credit        <= credit_n;
            cnt           <= cnt_n;
            coin_reject   <= reject_n;
            dispense      <= dispense_n;
            change_nickel <= change_n;
            busy          <= busy_n;
        end
    end

endmodule

// File: tb/tb_vend_credit_controller.sv
// Directed self-checking bench for vend_credit_controller with hand-computed expectations.
module tb_vend_credit_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       select = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] credit;
    logic       coin_reject, dispense, change_nickel, busy;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    vend_credit_controller #(.PRICE_UNITS(7), .MAX_UNITS(12), .VEND_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .select(select), .cancel(cancel), .credit(credit), .coin_reject(coin_reject),
        .dispense(dispense), .change_nickel(change_nickel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        cyc();
        coin_valid = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int c, input int rj, input int d, input int ch, input int b);
        chk({tag, ".credit"}, 32'(credit), 32'(c));
        chk({tag, ".reject"}, 32'(coin_reject), 32'(rj));
        chk({tag, ".dispense"}, 32'(dispense), 32'(d));
        chk({tag, ".change"}, 32'(change_nickel), 32'(ch));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // 1: reset mid-VEND with credit 3
        coin(2'b10); chk("t1.q1", 32'(credit), 5);
        coin(2'b10); chk("t1.q2", 32'(credit), 10);
        select = 1'b1; cyc(); select = 1'b0;
        chk_all("t1.vend0", 3, 0, 1, 0, 1);
        cyc();
        chk("t1.vend1", 32'(dispense), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk_all("t1.rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t1.nochange", 32'(change_nickel), 0);
            chk("t1.credit0", 32'(credit), 0);
        end

        // 2: quarter + dime, exact price
        coin(2'b10); chk("t2.q", 32'(credit), 5);
        coin(2'b01); chk("t2.d", 32'(credit), 7);
        select = 1'b1; cyc(); select = 1'b0;
        chk_all("t2.vend0", 0, 0, 1, 0, 1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk_all("t2.vend", 0, 0, 1, 0, 1);
        end
        cyc();
        chk_all("t2.idle", 0, 0, 0, 0, 0);
        cyc();
        chk_all("t2.idle2", 0, 0, 0, 0, 0);

        // 3: two quarters, vend, 3 nickels change
        coin(2'b10); coin(2'b10);
        chk("t3.fill", 32'(credit), 10);
        select = 1'b1; cyc(); select = 1'b0;
        chk_all("t3.vend0", 3, 0, 1, 0, 1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk_all("t3.vend", 3, 0, 1, 0, 1);
        end
        cyc(); chk_all("t3.chg3", 3, 0, 0, 1, 1);
        cyc(); chk_all("t3.chg2", 2, 0, 0, 1, 1);
        cyc(); chk_all("t3.chg1", 1, 0, 0, 1, 1);
        cyc(); chk_all("t3.done", 0, 0, 0, 0, 0);

        // 4: ceiling, then slug at zero
        coin(2'b10); coin(2'b10); coin(2'b01);
        chk("t4.full", 32'(credit), 12);
        coin(2'b00);
        chk_all("t4.over", 12, 1, 0, 0, 0);
        cyc();
        chk_all("t4.over2", 12, 0, 0, 0, 0);
        cancel = 1'b1; cyc(); cancel = 1'b0;
        chk_all("t4.ref12", 12, 0, 0, 1, 1);
        for (int i = 1; i < 12; i++) begin
            cyc();
            chk_all("t4.ref", 12 - i, 0, 0, 1, 1);
        end
        cyc(); chk_all("t4.empty", 0, 0, 0, 0, 0);
        coin(2'b11);
        chk_all("t4.slug", 0, 1, 0, 0, 0);
        cyc();
        chk("t4.slug2", 32'(coin_reject), 0);

        // 5: insufficient select, then cancel+select+coin together
        coin(2'b10);
        select = 1'b1; cyc(); select = 1'b0;
        chk_all("t5.nosel", 5, 0, 0, 0, 0);
        coin(2'b00); chk("t5.six", 32'(credit), 6);
        select = 1'b1; cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'b00;
        cyc();
        select = 1'b0; cancel = 1'b0; coin_valid = 1'b0;
        chk_all("t5.ref6", 6, 1, 0, 1, 1);
        for (int i = 1; i < 6; i++) begin
            cyc();
            chk_all("t5.ref", 6 - i, 0, 0, 1, 1);
        end
        cyc(); chk_all("t5.done", 0, 0, 0, 0, 0);

        // 6: dimes during VEND and REFUND are rejected
        coin(2'b10); coin(2'b10);
        select = 1'b1; cyc(); select = 1'b0;
        chk_all("t6.vend0", 3, 0, 1, 0, 1);
        coin(2'b01);
        chk_all("t6.vdime", 3, 1, 1, 0, 1);
        cyc(); chk_all("t6.vend2", 3, 0, 1, 0, 1);
        cyc(); chk_all("t6.vend3", 3, 0, 1, 0, 1);
        cyc(); chk_all("t6.chg3", 3, 0, 0, 1, 1);
        coin(2'b01);
        chk_all("t6.rdime", 2, 1, 0, 1, 1);
        cyc(); chk_all("t6.chg1", 1, 0, 0, 1, 1);
        cyc(); chk_all("t6.done", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
